ysyx_22050598_ex_div: RTL

Iterative radix-2 integer divider for the EX stage. It serves the RV64M divide/remainder instructions: DIV, DIVU, REM, REMU and the word forms DIVW, DIVUW, REMW, REMUW. It takes operands from the ID/EX pipeline outputs when the decoded divrem flag is set, and runs over multiple cycles while EX holds the ID/EX register stalled. It returns quotient and remainder through a valid/ready handshake toward the EX/MEM boundary.

---
 rtl/ysyx_22050598_ex_div.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050598_ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU and word forms).
// Fast paths (divide-by-zero, signed overflow) skip CALC/FIX and land in DONE on the accept edge.
module ysyx_22050598_ex_div #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            div_signed,
   input  logic            div_word,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e          state_q, state_d;
   logic [6:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN-1:0] qres_q, qres_d, rres_q, rres_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d, word_q, word_d;

   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_sx32, q_fix, r_fix;
   logic            a_neg, b_neg, div_zero, ovf, ge;
   logic [XLEN:0]   r_sh, r_sub;

   // Operand conditioning at width W (32 for word ops, else 64)
   always_comb begin
      a_ext    = div_word ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
      b_ext    = div_word ? {{32{div_signed & divisor[31]}}, divisor[31:0]} : divisor;
      a_sx32   = div_word ? {{32{dividend[31]}}, dividend[31:0]} : dividend;
      a_neg    = div_signed & a_ext[XLEN-1];
      b_neg    = div_signed & b_ext[XLEN-1];
      a_abs    = a_neg ? -a_ext : a_ext;
      b_abs    = b_neg ? -b_ext : b_ext;
      div_zero = div_word ? (divisor[31:0] == 32'd0) : (divisor == '0);
      ovf      = div_signed & (div_word
                 ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == 32'hFFFF_FFFF)
                 : (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1));
   end

   // One restoring step; r_sh < 2*dvs so the 65-bit difference sign is exact
   always_comb begin
      r_sh  = {rem_q, quo_q[XLEN-1]};
      r_sub = r_sh - {1'b0, dvs_q};
      ge    = ~r_sub[XLEN];
      q_fix = qneg_q ? -quo_q : quo_q;
      r_fix = rneg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      word_d  = word_q;
      qres_d  = qres_q;
      rres_d  = rres_q;
      case (state_q)
         IDLE: if (div_valid) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            word_d = div_word;
            dvs_d  = b_abs;
            rem_d  = '0;
            // Word dividend sits in the upper half so 32 shifts bring it through
            quo_d  = div_word ? {a_abs[31:0], 32'd0} : a_abs;
            cnt_d  = div_word ? 7'd32 : 7'd64;
            if (div_zero) begin
               qres_d  = '1;
               rres_d  = a_sx32;
               state_d = DONE;
            end else if (ovf) begin
               qres_d  = a_ext;
               rres_d  = '0;
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ge};
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) state_d = FIX;
         end
         FIX: begin
            qres_d  = word_q ? {{32{q_fix[31]}}, q_fix[31:0]} : q_fix;
            rres_d  = word_q ? {{32{r_fix[31]}}, r_fix[31:0]} : r_fix;
            state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         qres_d  = qres_q;
         rres_d  = rres_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         word_q  <= 1'b0;
         qres_q  <= '0;
         rres_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         word_q  <= word_d;
         qres_q  <= qres_d;
         rres_q  <= rres_d;
      end
   end

   assign div_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign quotient  = qres_q;
   assign remainder = rres_q;
endmodule
